note_recorder: RTL and testbench
================================

Name: note_recorder

Overview:
- Write side of the note store that the playback controller reads.
- Debounces the active-low load button and captures the note-switch value on each accepted press.
- Writes the value into a DEPTH-entry note memory and keeps the recorded-note count.
- Serves registered reads by playback index, so the playback FSM only steps an index from 0 to notes_recorded-1.

Parameters:
- NOTE_W, 4, width of one stored note code.
- DEPTH, 16, number of note slots; must be a power of 2.
- DB_CYC, 500000, cycles load_n must be stable before a press or release is accepted (10 ms at 50 MHz).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- load_n  in  1  raw active-low record button; asynchronous to clk.
- note_in  in  NOTE_W  note switches; sampled in the WRITE cycle.
- clear  in  1  synchronous single-cycle pulse; erases the recording.
- rd_idx  in  log2(DEPTH)  playback index; 0 = oldest recorded note.
- rd_note  out  NOTE_W  note at rd_idx; registered.
- notes_recorded  out  log2(DEPTH)+1  number of valid notes, 0..DEPTH.
- full  out  1  high when notes_recorded == DEPTH.
- wr_ack  out  1  one-cycle pulse in the cycle a note is written.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, active-high) values:
  - rd_note=0, notes_recorded=0, full=0, wr_ack=0, busy=0.
  - FSM in IDLE; write pointer and base pointer at 0.
  - Memory contents are not cleared.
- load_n passes through a 2-flop synchronizer (load_s). Press and release detection use load_s only.
- FSM states:
  - IDLE: when load_s==0, clear the debounce counter and go to PRESS_DB.
  - PRESS_DB: count while load_s==0. If load_s returns to 1 before the count reaches DB_CYC-1, go back to IDLE (glitch rejected). When the count reaches DB_CYC-1, go to WRITE.
  - WRITE: lasts exactly one cycle. mem[wr_ptr] <= note_in, wr_ack=1, then go to RELEASE_DB. If full and the overwrite feature is absent, the write is suppressed and wr_ack stays 0.
  - RELEASE_DB: count while load_s==1. Any return to 0 restarts the count. When the count reaches DB_CYC-1, go to IDLE.
- Result: exactly one note per physical press, however long the button is held.
- Press latency: from the first synchronized low to the wr_ack pulse is DB_CYC+1 cycles.
- On an accepted write: wr_ptr <= wr_ptr+1, wrapping modulo DEPTH. notes_recorded increments and saturates at DEPTH. full is a registered compare.
- Read path: rd_note <= mem[(base+rd_idx) mod DEPTH] on every clk, giving 1-cycle latency.
  - Reads of rd_idx >= notes_recorded return stale data. The consumer must not use them.
  - A read and a write to the same slot in the same cycle returns the old data.
- clear:
  - Sets notes_recorded=0, full=0, wr_ptr=0, base=0.
  - Forces the FSM to RELEASE_DB, so a held button is not recorded again.
  - clear coinciding with WRITE: clear wins, no write occurs, wr_ack=0.
- Reset in mid-debounce: everything returns to reset values. A still-held button then records a new note after the full debounce.
- Debounce counter width is log2(DB_CYC)+1 bits. DB_CYC=1 is legal and means the edge is accepted the next cycle.

Optional Feature:
- Macro: NOTE_REC_OVERWRITE_EN.
- Defined: when full, WRITE still stores the note at wr_ptr (the oldest slot), pulses wr_ack, and advances both wr_ptr and base by 1. notes_recorded stays DEPTH. rd_idx 0 always maps to the oldest surviving note.
- Undefined: base is tied to 0 and no logic is generated for it. Writes while full are dropped with no wr_ack, and the FSM still walks WRITE→RELEASE_DB.

Decomposition:
- Shared package music_pkg holds:
  - NOTE_W and DEPTH defaults;
  - the state encoding for this block (IDLE=2'b00, PRESS_DB=2'b01, WRITE=2'b10, RELEASE_DB=2'b11);
  - the clock-rate constant used for DB_CYC derivation.
- One sub-module: note_mem, a DEPTH×NOTE_W simple dual-port RAM with registered read (one write port, one read port). The FSM, pointers and debouncer stay in note_recorder.

Test Plan:
- DB_CYC=4; hold load_n low for 20 cycles with note_in=4'hA → exactly one wr_ack, notes_recorded=1; rd_idx=0 gives rd_note=4'hA one cycle later.
- Pulse load_n low for 2 cycles (shorter than DB_CYC) → no wr_ack, notes_recorded stays 0, FSM back in IDLE.
- Record 16 notes 0..F, then a 17th note 5 → without the macro: full=1, count=16, no 17th wr_ack, rd_idx=0 gives 0. With NOTE_REC_OVERWRITE_EN: wr_ack pulses, rd_idx=0 gives 1, rd_idx=15 gives 5.
- Assert clear in the WRITE cycle of a press → wr_ack=0, notes_recorded=0, busy stays high until load_n has been high for DB_CYC cycles.
- Assert reset mid-PRESS_DB while load_n is held low → outputs reset at once. After reset release, one note is recorded DB_CYC+3 cycles later (2 synchronizer cycles plus debounce plus WRITE).
- Toggle load_n 1-0-1 every cycle during RELEASE_DB → no second write; IDLE is reached only after 4 consecutive high cycles.

Source files
------------

// File: rtl/music_pkg.sv
// Shared constants and state encoding for the music recorder/player.
// Clock rate and debounce time feed the default debounce length.
package music_pkg;

  localparam int NOTE_W_DEF = 4;
  localparam int DEPTH_DEF  = 16;
  localparam int CLK_HZ     = 50_000_000;
  localparam int DB_MS      = 10;

  function automatic int db_cycles(input int hz, input int ms);
    return (hz / 1000) * ms;
  endfunction

  localparam int DB_CYC_DEF = db_cycles(CLK_HZ, DB_MS);

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    PRESS_DB   = 2'b01,
    WRITE      = 2'b10,
    RELEASE_DB = 2'b11
  } rec_state_t;

endpackage

// File: rtl/note_mem.sv
// Simple dual-port note RAM: one write port, one registered read port.
// A same-slot read and write in one cycle returns the old data.
module note_mem #(
  parameter int W     = 4,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_data <= '0;
    else       rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/note_recorder.sv
// Debounced record button writing notes into a circular note store.
// Define NOTE_REC_OVERWRITE_EN to overwrite the oldest note when full.
module note_recorder
  import music_pkg::*;
#(
  parameter int NOTE_W = NOTE_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int DB_CYC = DB_CYC_DEF,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_n,
  input  logic [NOTE_W-1:0] note_in,
  input  logic              clear,
  input  logic [AW-1:0]     rd_idx,
  output logic [NOTE_W-1:0] rd_note,
  output logic [AW:0]       notes_recorded,
  output logic              full,
  output logic              wr_ack,
  output logic              busy
);

  localparam int CW = $clog2(DB_CYC) + 1;
  localparam logic [CW-1:0] CNT_END = CW'(DB_CYC - 1);
  localparam logic [AW:0]   LAST    = (AW+1)'(DEPTH - 1);

  rec_state_t    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    sync;
  logic          load_s;
  logic          write_go;
  logic          wr_en;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] base;

  assign load_s = sync[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync <= 2'b11;
    else       sync <= {sync[0], load_n};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    write_go  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!load_s) begin
          cnt_nxt   = '0;
          state_nxt = PRESS_DB;
        end
      end
      PRESS_DB: begin
        if (load_s)              state_nxt = IDLE;
        else if (cnt == CNT_END) state_nxt = WRITE;
        else                     cnt_nxt   = cnt + 1'b1;
      end
      WRITE: begin
        write_go  = 1'b1;
        cnt_nxt   = '0;
        state_nxt = RELEASE_DB;
      end
      RELEASE_DB: begin
        if (!load_s)             cnt_nxt   = '0;
        else if (cnt == CNT_END) state_nxt = IDLE;
        else                     cnt_nxt   = cnt + 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
    // a clear parks the FSM so a held button cannot re-record
    if (clear) begin
      state_nxt = RELEASE_DB;
      cnt_nxt   = '0;
    end
  end

`ifdef NOTE_REC_OVERWRITE_EN
  assign wr_en = write_go && !clear;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)              base <= '0;
    else if (clear)         base <= '0;
    else if (wr_en && full) base <= base + 1'b1;
  end
`else
  assign wr_en = write_go && !clear && !full;
  assign base  = '0;
`endif

  assign wr_ack = wr_en;
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr         <= '0;
      notes_recorded <= '0;
      full           <= 1'b0;
    end else if (clear) begin
      wr_ptr         <= '0;
      notes_recorded <= '0;
      full           <= 1'b0;
    end else if (wr_en) begin
      wr_ptr <= wr_ptr + 1'b1;
      if (!full) begin
        notes_recorded <= notes_recorded + 1'b1;
        full           <= (notes_recorded == LAST);
      end
    end
  end

  note_mem #(
    .W     (NOTE_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .we      (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (note_in),
    .rd_addr (base + rd_idx),
    .rd_data (rd_note)
  );

endmodule

// File: tb/tb_note_recorder.sv
// Randomized bench for note_recorder against a queue-based note model.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_note_recorder;

  localparam int DB = 4;
  localparam int D  = 16;
`ifdef NOTE_REC_OVERWRITE_EN
  localparam bit OVR = 1'b1;
`else
  localparam bit OVR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       load_n;
  logic [3:0] note_in;
  logic       clear;
  logic [3:0] rd_idx;
  logic [3:0] rd_note;
  logic [4:0] notes_recorded;
  logic       full;
  logic       wr_ack;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int acks;
  int ack_step;
  int step_no;
  logic [3:0] q[$];

  note_recorder #(
    .NOTE_W (4),
    .DEPTH  (D),
    .DB_CYC (DB)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .load_n         (load_n),
    .note_in        (note_in),
    .clear          (clear),
    .rd_idx         (rd_idx),
    .rd_note        (rd_note),
    .notes_recorded (notes_recorded),
    .full           (full),
    .wr_ack         (wr_ack),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    step_no++;
    if (wr_ack === 1'b1) begin
      acks++;
      if (ack_step < 0) ack_step = step_no;
    end
  endtask

  task automatic arm();
    acks     = 0;
    ack_step = -1;
    step_no  = 0;
  endtask

  task automatic model_write(input logic [3:0] n);
    if (q.size() < D) q.push_back(n);
    else if (OVR) begin
      void'(q.pop_front());
      q.push_back(n);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_cnt"}, notes_recorded, q.size());
    chk({tag, "_full"}, full, q.size() == D);
  endtask

  task automatic press(input logic [3:0] n, input int len, input int gap);
    bit exp_ack;
    exp_ack = (len >= DB + 1) && (q.size() < D || OVR);
    note_in = n;
    load_n  = 1'b0;
    arm();
    repeat (len) step();
    load_n = 1'b1;
    repeat (gap) step();
    chk("press_acks", acks, exp_ack ? 1 : 0);
    if (exp_ack) begin
      chk("press_lat", ack_step, DB + 3);
      model_write(n);
    end
    check_state("press");
    chk("press_idle", busy, 0);
  endtask

  task automatic read_check(input int idx);
    rd_idx = 4'(idx);
    step();
    chk("rd_note", rd_note, q[idx]);
  endtask

  task automatic release_check(input string tag);
    load_n = 1'b1;
    repeat (DB + 1) step();
    chk({tag, "_busy_hold"}, busy, 1);
    step();
    chk({tag, "_busy_idle"}, busy, 0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    q.delete();
    repeat (DB + 2) step();
    check_state("clear");
  endtask

  initial begin
    reset   = 1'b1;
    load_n  = 1'b1;
    clear   = 1'b0;
    note_in = '0;
    rd_idx  = '0;
    arm();
    repeat (3) @(negedge clk);
    chk("rst_rd_note", rd_note, 0);
    chk("rst_cnt", notes_recorded, 0);
    chk("rst_full", full, 0);
    chk("rst_ack", wr_ack, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    repeat (2) step();

    // long hold records one note
    press(4'hA, 20, 14);
    read_check(0);

    // short glitch rejected
    press(4'h3, 2, 14);

    // fill, then one more
    do_clear();
    for (int i = 0; i < D; i++) press(4'(i), 6, 10);
    press(4'h5, 6, 10);
    chk("fill_full", full, 1);
    read_check(0);
    read_check(D - 1);

    // clear during the WRITE cycle
    do_clear();
    note_in = 4'h3;
    load_n  = 1'b0;
    arm();
    repeat (DB + 2) step();
    @(posedge clk);
    #1 clear = 1'b1;
    step();
    @(posedge clk);
    #1 clear = 1'b0;
    step();
    chk("clrw_ack", acks, 0);
    check_state("clrw");
    chk("clrw_busy", busy, 1);
    repeat (10) step();
    chk("clrw_noack", acks, 0);
    release_check("clrw");

    // reset in the middle of press debounce
    press(4'h9, 8, 14);
    press(4'h6, 8, 14);
    note_in = 4'hC;
    load_n  = 1'b0;
    arm();
    repeat (3) step();
    reset = 1'b1;
    #1;
    q.delete();
    chk("mrst_cnt", notes_recorded, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_rd", rd_note, 0);
    step();
    reset = 1'b0;
    arm();
    repeat (12) step();
    chk("mrst_acks", acks, 1);
    chk("mrst_lat", ack_step, DB + 3);
    model_write(4'hC);
    release_check("mrst");
    check_state("mrst");
    read_check(0);

    // bouncing release
    note_in = 4'h7;
    load_n  = 1'b0;
    arm();
    repeat (10) step();
    for (int i = 0; i < 10; i++) begin
      load_n = (i % 2 == 0);
      step();
    end
    chk("tog_acks", acks, 1);
    model_write(4'h7);
    release_check("tog");
    check_state("tog");

    // random presses
    for (int k = 0; k < 40; k++) begin
      press(4'($urandom_range(0, 15)), $urandom_range(1, 12), 14);
      if (q.size() > 0) read_check($urandom_range(0, q.size() - 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
